frac_half_search: RTL and testbench
===================================

# frac_half_search

Parametrised half-pel motion refinement stage for the motion-estimation path. It streams one BLK×BLK current block and a (BLK+1)×(BLK+1) reference window row by row. It builds the four half-pel candidates by bilinear averaging, accumulates a SAD for each, and reports the best candidate as a quarter-pel motion vector. It sits after the integer search and supersedes the fixed 8×8 fractional-search stub.

## Interface
- BLK, 8, block width and height in pixels; legal range 2..16.
- PIXW, 8, bits per pixel.
- SADW, PIXW+2*$clog2(BLK), SAD accumulator width; derived, do not override.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high; clock clk.
- in_valid  in  1  beat qualifier.
- in_ready  out  1  block accepts a beat when in_valid && in_ready.
- ref_row  in  (BLK+1)*PIXW  reference row; pixel i at [i*PIXW +: PIXW], pixel 0 leftmost.
- cur_row  in  BLK*PIXW  current-block row, same packing.
- out_valid  out  1  one-cycle result pulse.
- mvx, mvy  out  3 each  best vector in quarter-pel units; each is 0 or 2.
- best_idx  out  2  candidate index 0..3.
- best_sad  out  SADW  SAD of the winning candidate.

## Operation
- A block is BLK+1 accepted beats, numbered k=0..BLK.
- Beat k carries ref row k.
- Beats k<BLK also carry cur row k. cur_row is ignored on beat BLK.
- Internally the block registers the previous ref row R0 and the previous cur row C.
- On each beat k≥1 it processes cur row C against ref rows R0 (row k-1) and R1 (row k, live input). For pixel i, with a=R0[i], b=R0[i+1], c=R1[i], d=R1[i+1]:
  - idx0 (0,0): a
  - idx1 (2,0): (a+b+1)>>1
  - idx2 (0,2): (a+c+1)>>1
  - idx3 (2,2): (a+b+c+d+2)>>2
- Intermediate sums use PIXW+2 bits. Results are truncated back to PIXW.
- sad[n] += Σ_i |C[i] − pred_n[i]|, unsigned. No saturation is needed, because the maximum is BLK²·(2^PIXW−1) < 2^SADW.
- State machine:
  - IDLE: in_ready=1. An accepted beat is beat 0: clear all four sad to 0, load R0 and C, set cnt=1, go to RECV.
  - RECV: in_ready=1. An accepted beat updates the accumulators, loads R0 and C, and increments cnt. When the accepted beat has cnt==BLK, go to CMP.
  - CMP: in_ready=0 and in_valid is ignored. On the edge, select the minimum sad using strict less-than in index order 0→3, so ties go to the lowest index. Register best_idx, best_sad, mvx=2·idx[0] and mvy=2·idx[1]. Set out_valid=1 and go to IDLE.
- Bubbles: in_valid low in RECV holds all state, with no timeout.
- Result outputs hold their values until the next CMP. out_valid is high for exactly one cycle.

## Timing
- Reset values: state=IDLE, cnt=0, all four sad=0, out_valid=0, mvx=0, mvy=0, best_idx=0, best_sad=0. in_ready=1 combinationally from IDLE.
- Reset mid-block discards the partial block. The next accepted beat is beat 0.
- Reset in CMP suppresses that cycle's out_valid.
- Accumulation is single-cycle per beat, with a combinational SAD tree into the registers.
- Latency: the last beat is accepted on edge E. The machine is in CMP during cycle E..E+1. out_valid is high in the cycle following edge E+1.
- Throughput: BLK+2 cycles per block with no bubbles.
- Beat 0 of the next block may be accepted in the cycle where out_valid=1, because the state is IDLE by then.
- The minimum block is BLK=2: 3 beats, then CMP.

## Test plan
Defaults BLK=8, PIXW=8 unless stated.
- Uniform block, ref all 100 and cur all 100 → four SADs of 0. All tie, so best_idx=0, mvx=0, mvy=0, best_sad=0, and out_valid arrives 2 edges after the last beat.
- Ref columns alternating 0,200,0,… (same pattern in every row), cur all 100 → sad0=6400, sad1=0, sad2=6400, sad3=0. The tie resolves to idx1: mvx=2, mvy=0, best_sad=0.
- Ref rows alternating all-0 and all-200, cur all 100 → idx2: mvx=0, mvy=2, best_sad=0.
- Ref all 0, cur all 255 → best_sad=16320 with no overflow, best_idx=0.
- Block with in_valid deasserted for 3 random gaps, then back-to-back blocks with beat 0 on the out_valid cycle → results identical to the gap-free run, and in_ready low only in CMP cycles.
- Reset after beat 4, then a full uniform-100 block → exactly one out_valid, with best_sad=0 and no contamination from the aborted block.
- BLK=2 parameter build with a directed 3-beat block → hand-computed SADs match.

Source files
------------

// File: rtl/frac_half_search.sv
// Half-pel motion refinement: streams BLK+1 reference rows against BLK current rows, accumulates
// a SAD for each of the four bilinear half-pel candidates and reports the cheapest as a quarter-pel vector.
module frac_half_search #(
   parameter int BLK  = 8,
   parameter int PIXW = 8,
   parameter int SADW = PIXW + 2*$clog2(BLK)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [(BLK+1)*PIXW-1:0]   ref_row,
   input  logic [BLK*PIXW-1:0]       cur_row,
   output logic                      out_valid,
   output logic [2:0]                mvx,
   output logic [2:0]                mvy,
   output logic [1:0]                best_idx,
   output logic [SADW-1:0]           best_sad
);
   localparam int CW = $clog2(BLK + 2);
   localparam int SW = PIXW + 2;

   typedef enum logic [1:0] {S_IDLE, S_RECV, S_CMP} state_t;

   state_t                    state_q, state_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic [(BLK+1)*PIXW-1:0]   r0_q, r0_d;
   logic [BLK*PIXW-1:0]       c_q, c_d;
   logic [SADW-1:0]           sad_q [4];
   logic [SADW-1:0]           sad_d [4];
   logic [SADW-1:0]           row_sad [4];
   logic [3:0][BLK-1:0][PIXW-1:0] diff;

   logic                      out_valid_q;
   logic [1:0]                best_idx_q;
   logic [SADW-1:0]           best_sad_q;
   logic [1:0]                min_idx;
   logic [SADW-1:0]           min_sad;

   // Per-pixel candidate predictions from the stored row (a,b) and the live row (c,d).
   for (genvar gi = 0; gi < BLK; gi++) begin : g_pix
      logic [SW-1:0]            a, b, c, d;
      logic [SW-1:0]            s1, s2, s3;
      logic [3:0][PIXW-1:0]     pred;
      logic [PIXW-1:0]          cur;

      assign a   = SW'(r0_q[gi*PIXW +: PIXW]);
      assign b   = SW'(r0_q[(gi+1)*PIXW +: PIXW]);
      assign c   = SW'(ref_row[gi*PIXW +: PIXW]);
      assign d   = SW'(ref_row[(gi+1)*PIXW +: PIXW]);
      assign cur = c_q[gi*PIXW +: PIXW];

      assign s1 = (a + b + SW'(1)) >> 1;
      assign s2 = (a + c + SW'(1)) >> 1;
      assign s3 = (a + b + c + d + SW'(2)) >> 2;

      assign pred[0] = a[PIXW-1:0];
      assign pred[1] = s1[PIXW-1:0];
      assign pred[2] = s2[PIXW-1:0];
      assign pred[3] = s3[PIXW-1:0];

      for (genvar gn = 0; gn < 4; gn++) begin : g_cand
         assign diff[gn][gi] = (cur >= pred[gn]) ? (cur - pred[gn]) : (pred[gn] - cur);
      end
   end

   always_comb begin
      for (int n = 0; n < 4; n++) begin
         row_sad[n] = '0;
         for (int i = 0; i < BLK; i++) begin
            row_sad[n] = row_sad[n] + SADW'(diff[n][i]);
         end
      end
   end

   // Strict less-than scan keeps the lowest index on ties.
   always_comb begin
      min_idx = 2'd0;
      min_sad = sad_q[0];
      for (int n = 1; n < 4; n++) begin
         if (sad_q[n] < min_sad) begin
            min_sad = sad_q[n];
            min_idx = 2'(n);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      r0_d     = r0_q;
      c_d      = c_q;
      in_ready = 1'b0;
      for (int n = 0; n < 4; n++) sad_d[n] = sad_q[n];

      case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               for (int n = 0; n < 4; n++) sad_d[n] = '0;
               r0_d    = ref_row;
               c_d     = cur_row;
               cnt_d   = CW'(1);
               state_d = S_RECV;
            end
         end
         S_RECV: begin
            in_ready = 1'b1;
            if (in_valid) begin
               for (int n = 0; n < 4; n++) sad_d[n] = sad_q[n] + row_sad[n];
               r0_d  = ref_row;
               c_d   = cur_row;
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(BLK)) state_d = S_CMP;
            end
         end
         S_CMP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         r0_q        <= '0;
         c_q         <= '0;
         for (int n = 0; n < 4; n++) sad_q[n] <= '0;
         out_valid_q <= 1'b0;
         best_idx_q  <= 2'd0;
         best_sad_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         r0_q        <= r0_d;
         c_q         <= c_d;
         for (int n = 0; n < 4; n++) sad_q[n] <= sad_d[n];
         out_valid_q <= (state_q == S_CMP);
         if (state_q == S_CMP) begin
            best_idx_q <= min_idx;
            best_sad_q <= min_sad;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign best_idx  = best_idx_q;
   assign best_sad  = best_sad_q;
   assign mvx       = {1'b0, best_idx_q[0], 1'b0};
   assign mvy       = {1'b0, best_idx_q[1], 1'b0};

endmodule

// File: tb/tb_frac_half_search.sv
// Bench for frac_half_search: directed blocks on a BLK=8 and a BLK=2 instance, results checked by
// queue-based scoreboards popped from monitors whenever out_valid is seen.
module tb_frac_half_search;
   typedef struct {
      int idx;
      int sad;
      int mvx;
      int mvy;
      int cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   // BLK=8 instance
   logic        in_valid8 = 1'b0;
   logic        in_ready8;
   logic [71:0] ref_row8 = '0;
   logic [63:0] cur_row8 = '0;
   logic        out_valid8;
   logic [2:0]  mvx8, mvy8;
   logic [1:0]  best_idx8;
   logic [13:0] best_sad8;

   // BLK=2 instance
   logic        in_valid2 = 1'b0;
   logic        in_ready2;
   logic [23:0] ref_row2 = '0;
   logic [15:0] cur_row2 = '0;
   logic        out_valid2;
   logic [2:0]  mvx2, mvy2;
   logic [1:0]  best_idx2;
   logic [9:0]  best_sad2;

   exp_t q8[$];
   exp_t q2[$];
   logic prev_low8 = 1'b0;

   frac_half_search #(.BLK(8), .PIXW(8)) dut8 (
      .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
      .ref_row(ref_row8), .cur_row(cur_row8), .out_valid(out_valid8),
      .mvx(mvx8), .mvy(mvy8), .best_idx(best_idx8), .best_sad(best_sad8)
   );

   frac_half_search #(.BLK(2), .PIXW(8)) dut2 (
      .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
      .ref_row(ref_row2), .cur_row(cur_row2), .out_valid(out_valid2),
      .mvx(mvx2), .mvy(mvy2), .best_idx(best_idx2), .best_sad(best_sad2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Patterns: 0 uniform 100, 1 alternating columns 0/200, 2 alternating rows 0/200, 3 ref 0 / cur 255
   function automatic logic [71:0] mkref8(input int pat, input int k);
      logic [71:0] v;
      int p;
      v = '0;
      for (int i = 0; i < 9; i++) begin
         case (pat)
            0:       p = 100;
            1:       p = (i % 2 == 1) ? 200 : 0;
            2:       p = (k % 2 == 1) ? 200 : 0;
            default: p = 0;
         endcase
         v[i*8 +: 8] = 8'(p);
      end
      return v;
   endfunction

   function automatic logic [63:0] mkcur8(input int pat);
      logic [63:0] v;
      for (int i = 0; i < 8; i++) v[i*8 +: 8] = (pat == 3) ? 8'd255 : 8'd100;
      return v;
   endfunction

   task automatic beat8(input logic [71:0] r, input logic [63:0] c);
      int guard;
      guard = 0;
      ref_row8  = r;
      cur_row8  = c;
      in_valid8 = 1'b1;
      while (in_ready8 !== 1'b1 && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      if (in_ready8 !== 1'b1) chk("ready_timeout8", int'(in_ready8), 1);
      @(posedge clk); #1;
      in_valid8 = 1'b0;
   endtask

   task automatic block8(input int pat, input int gap_mask, input int e_idx, input int e_sad);
      exp_t e;
      for (int k = 0; k <= 8; k++) begin
         if (gap_mask[k]) begin
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
         end
         beat8(mkref8(pat, k), mkcur8(pat));
      end
      e.idx = e_idx;
      e.sad = e_sad;
      e.mvx = 2 * (e_idx % 2);
      e.mvy = 2 * (e_idx / 2);
      e.cyc = cyc + 1;
      q8.push_back(e);
   endtask

   // BLK=2 directed vectors: three ref rows of three pixels, two cur rows of two pixels
   int t_ref [3][3][3] = '{
      '{'{10, 20, 30}, '{40, 50, 60}, '{0, 0, 0}},
      '{'{0, 0, 0},    '{0, 0, 0},    '{0, 0, 0}},
      '{'{0, 4, 4},    '{4, 2, 6},    '{4, 2, 6}}
   };
   int t_cur [3][2][2] = '{
      '{'{30, 30},   '{10, 10}},
      '{'{255, 255}, '{255, 255}},
      '{'{3, 4},     '{3, 4}}
   };
   int t_idx [3] = '{2, 0, 3};
   int t_sad [3] = '{35, 1020, 0};

   task automatic block2(input int v);
      exp_t e;
      int guard;
      for (int k = 0; k <= 2; k++) begin
         for (int i = 0; i < 3; i++) ref_row2[i*8 +: 8] = 8'(t_ref[v][k][i]);
         for (int i = 0; i < 2; i++) cur_row2[i*8 +: 8] = (k < 2) ? 8'(t_cur[v][k][i]) : 8'd0;
         in_valid2 = 1'b1;
         guard = 0;
         while (in_ready2 !== 1'b1 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
         end
         if (in_ready2 !== 1'b1) chk("ready_timeout2", int'(in_ready2), 1);
         @(posedge clk); #1;
         in_valid2 = 1'b0;
      end
      e.idx = t_idx[v];
      e.sad = t_sad[v];
      e.mvx = 2 * (t_idx[v] % 2);
      e.mvy = 2 * (t_idx[v] / 2);
      e.cyc = cyc + 1;
      q2.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         prev_low8 = 1'b0;
      end else begin
         if (out_valid8) begin
            if (q8.size() == 0) begin
               chk("spurious_out8", 1, 0);
            end else begin
               e = q8.pop_front();
               $display("blk8 result idx=%0d sad=%0d mvx=%0d mvy=%0d cycle=%0d",
                        best_idx8, best_sad8, mvx8, mvy8, cyc);
               chk("best_idx8", int'(best_idx8), e.idx);
               chk("best_sad8", int'(best_sad8), e.sad);
               chk("mvx8", int'(mvx8), e.mvx);
               chk("mvy8", int'(mvy8), e.mvy);
               chk("latency8", cyc, e.cyc);
            end
         end
         if (!in_ready8 || prev_low8) chk("ready_low_only_in_cmp8", int'(out_valid8), int'(prev_low8));
         prev_low8 = !in_ready8;

         if (out_valid2) begin
            if (q2.size() == 0) begin
               chk("spurious_out2", 1, 0);
            end else begin
               e = q2.pop_front();
               $display("blk2 result idx=%0d sad=%0d mvx=%0d mvy=%0d cycle=%0d",
                        best_idx2, best_sad2, mvx2, mvy2, cyc);
               chk("best_idx2", int'(best_idx2), e.idx);
               chk("best_sad2", int'(best_sad2), e.sad);
               chk("mvx2", int'(mvx2), e.mvx);
               chk("mvy2", int'(mvy2), e.mvy);
               chk("latency2", cyc, e.cyc);
            end
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", int'(out_valid8), 0);
      chk("rst_in_ready", int'(in_ready8), 1);
      chk("rst_best_sad", int'(best_sad8), 0);
      chk("rst_best_idx", int'(best_idx8), 0);
      chk("rst_mvx", int'(mvx8), 0);
      chk("rst_mvy", int'(mvy8), 0);
      reset = 1'b0;
      @(posedge clk); #1;

      block8(0, 0, 0, 0);
      block8(1, 0, 1, 0);
      block8(2, 0, 2, 0);
      block8(3, 0, 0, 16320);
      repeat (3) @(posedge clk);
      #1;
      block8(1, 9'b100100100, 1, 0);
      block8(2, 0, 2, 0);
      block8(0, 0, 0, 0);
      repeat (4) @(posedge clk);
      #1;

      // Abort a block after beat 4; only the following clean block may produce a result.
      for (int k = 0; k <= 4; k++) beat8(mkref8(3, k), mkcur8(3));
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      block8(0, 0, 0, 0);
      repeat (4) @(posedge clk);
      #1;

      for (int v = 0; v < 3; v++) block2(v);
      repeat (6) @(posedge clk);
      #1;

      chk("pending_results8", q8.size(), 0);
      chk("pending_results2", q2.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
